// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if
//   Groups the button inputs and the mode outputs of one mode_sequencer.
//   Signals:
//     btn_next, btn_prev : raw asynchronous push buttons (driven by master)
//     lock               : synchronous; 1 = presses ignored, idle timer frozen
//     mode               : current mode, 0..N_MODES-1
//     mode_onehot        : one-hot decode of mode
//     mode_changed       : 1-cycle strobe, high in the first cycle a new mode is visible
//     idle_timeout       : 1-cycle strobe, high together with mode_changed when
//                          the idle timer forced the home mode
//   There is no valid/ready pair: the strobes are qualifiers for the cycle in
//   which they are high and are never held or back-pressured.
//   Modports: master = button/lock source, slave = the sequencer.
interface mode_sequencer_if #(
  parameter int N_MODES = 4
) ();
  localparam int MODE_W = $clog2(N_MODES);

  logic                btn_next;
  logic                btn_prev;
  logic                lock;
  logic [MODE_W-1:0]   mode;
  logic [N_MODES-1:0]  mode_onehot;
  logic                mode_changed;
  logic                idle_timeout;

  modport master (
    output btn_next, btn_prev, lock,
    input  mode, mode_onehot, mode_changed, idle_timeout
  );

  modport slave (
    input  btn_next, btn_prev, lock,
    output mode, mode_onehot, mode_changed, idle_timeout
  );
endinterface

// File: rtl/mode_sequencer.sv
// mode_sequencer
//   N-mode UI controller. Two raw buttons are synchronised, debounced and
//   edge-detected into single-cycle presses that step a mode register forward
//   or backward with wrap-around. Optional idle timer returns to HOME_MODE.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous, active-high reset
//     bus  : mode_sequencer_if.slave (buttons, lock, mode outputs and strobes)
module mode_sequencer #(
  parameter int N_MODES         = 4,
  parameter int HOME_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic             clk,
  input  logic             rst,
  mode_sequencer_if.slave  bus
);
  localparam int MODE_W = $clog2(N_MODES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int IDLE_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit POW2   = (N_MODES == (1 << MODE_W));

  localparam logic [MODE_W-1:0] HOME      = MODE_W'(HOME_MODE);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(N_MODES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  // Bit 0 = next, bit 1 = prev throughout the input path.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync0;
  logic [1:0]      r_sync1;
  logic [1:0]      r_db;
  logic [1:0]      r_db_prev;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  logic [MODE_W-1:0]  r_mode;
  logic               r_changed;
  logic               r_timeout;
  logic [IDLE_W-1:0]  r_idle;

  logic [MODE_W-1:0]  w_mode_nxt;
  logic [IDLE_W-1:0]  w_idle_nxt;
  logic               w_fire;
  logic               w_accept;
  logic               w_pn;
  logic               w_pp;
  logic               w_oor;
  logic [N_MODES-1:0] w_onehot;

  assign w_raw = {bus.btn_prev, bus.btn_next};

  // Synchroniser, debouncer and rising-edge press detector for both buttons.
  // The debounce counter only runs while the synchronised level disagrees
  // with the accepted level, so any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0     <= '0;
      r_sync1     <= '0;
      r_db        <= '0;
      r_db_prev   <= '0;
      r_press     <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync0   <= w_raw;
      r_sync1   <= r_sync0;
      r_db_prev <= r_db;
      r_press   <= r_db & ~r_db_prev;
      for (int b = 0; b < 2; b++) begin
        if (r_sync1[b] != r_db[b]) begin
          if (r_db_cnt[b] == DB_LAST) begin
            r_db[b]     <= r_sync1[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
          end
        end else begin
          r_db_cnt[b] <= '0;
        end
      end
    end
  end

  assign w_pn = r_press[0];
  assign w_pp = r_press[1];
  // Only a lone press moves the mode; simultaneous presses cancel out.
  assign w_accept = ~bus.lock & (w_pn ^ w_pp);
  // Codes above N_MODES-1 exist only when N_MODES is not a power of two.
  assign w_oor = !POW2 && (int'(r_mode) > N_MODES - 1);

  always_comb begin
    w_mode_nxt = r_mode;
    w_fire     = 1'b0;
    w_idle_nxt = r_idle;

    if (w_oor) begin
      w_mode_nxt = HOME;
    end else if (!bus.lock) begin
      if (w_pn & ~w_pp) begin
        w_mode_nxt = (r_mode == LAST_MODE) ? '0 : r_mode + 1'b1;
      end else if (w_pp & ~w_pn) begin
        w_mode_nxt = (r_mode == '0) ? LAST_MODE : r_mode - 1'b1;
      end else if (TO_EN && (r_mode != HOME) && (r_idle == IDLE_LAST)) begin
        // A press on the same edge takes the branches above, so it wins.
        w_mode_nxt = HOME;
        w_fire     = 1'b1;
      end
    end

    if (!TO_EN) begin
      w_idle_nxt = '0;
    end else if (bus.lock) begin
      w_idle_nxt = r_idle;
    end else if (w_accept || (r_mode == HOME) || w_fire) begin
      w_idle_nxt = '0;
    end else begin
      w_idle_nxt = r_idle + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= HOME;
      r_changed <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_changed <= (w_mode_nxt != r_mode);
      r_timeout <= w_fire;
      r_idle    <= w_idle_nxt;
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_MODES; i++) begin
      w_onehot[i] = (r_mode == MODE_W'(i));
    end
  end

  assign bus.mode         = r_mode;
  assign bus.mode_onehot  = w_onehot;
  assign bus.mode_changed = r_changed;
  assign bus.idle_timeout = r_timeout;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer
//   Three sequencers share one clock:
//     u_a : N=4, home 0, debounce 16, no timeout  (stepping, glitches, lock, random)
//     u_b : N=4, home 0, debounce 16, timeout 100 (idle return, lock delay)
//     u_c : N=5, home 2, debounce 4,  no timeout  (non power-of-two wrap, reset)
//   Each issued press predicts its mode update (value and cycle) from the
//   latency rule and modular stepping; monitors pop predictions on strobes.
module tb_mode_sequencer;
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  mode;
    logic        to;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_c;
  int   cyc;
  int   n_cmp;
  int   n_err;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  exp_t exp_q_c[$];

  int nmodes [3] = '{4, 4, 5};
  int home   [3] = '{0, 0, 2};
  int dbc    [3] = '{16, 16, 4};
  int mode_m [3];

  mode_sequencer_if #(.N_MODES(4)) if_a ();
  mode_sequencer_if #(.N_MODES(4)) if_b ();
  mode_sequencer_if #(.N_MODES(5)) if_c ();

  mode_sequencer #(.N_MODES(4), .HOME_MODE(0), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(0))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  mode_sequencer #(.N_MODES(4), .HOME_MODE(0), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(100))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  mode_sequencer #(.N_MODES(5), .HOME_MODE(2), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c));

  // ---------------- clock / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q_a.size();
      1:       return exp_q_b.size();
      default: return exp_q_c.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int d);
    case (d)
      0:       return exp_q_a[0];
      1:       return exp_q_b[0];
      default: return exp_q_c[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    case (d)
      0:       void'(exp_q_a.pop_front());
      1:       void'(exp_q_b.pop_front());
      default: void'(exp_q_c.pop_front());
    endcase
  endtask

  task automatic qpush(input int d, input int at, input int m, input bit to);
    exp_t e;
    e.cyc  = 32'(at);
    e.mode = 8'(m);
    e.to   = to;
    case (d)
      0:       exp_q_a.push_back(e);
      1:       exp_q_b.push_back(e);
      default: exp_q_c.push_back(e);
    endcase
  endtask

  task automatic qclear(input int d);
    case (d)
      0:       exp_q_a.delete();
      1:       exp_q_b.delete();
      default: exp_q_c.delete();
    endcase
  endtask

  // ---------------- monitor ----------------
  task automatic monitor(input int d, input logic chg, input logic to, input int m);
    exp_t e;
    if (qsize(d) > 0 && !chg) begin
      e = qfront(d);
      if (int'(e.cyc) < cyc) begin
        cmp($sformatf("dut%0d missing change due at cycle %0d", d, int'(e.cyc)), 0, 1);
        qpop(d);
      end
    end
    if (chg) begin
      if (qsize(d) == 0) begin
        cmp($sformatf("dut%0d unexpected mode_changed (mode %0d)", d, m), 1, 0);
      end else begin
        e = qfront(d);
        qpop(d);
        cmp($sformatf("dut%0d change cycle", d), cyc, int'(e.cyc));
        cmp($sformatf("dut%0d new mode", d), m, int'(e.mode));
        cmp($sformatf("dut%0d idle_timeout with change", d), int'(to), int'(e.to));
      end
    end else if (to) begin
      cmp($sformatf("dut%0d idle_timeout without mode_changed", d), 1, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitor(0, if_a.mode_changed, if_a.idle_timeout, int'(if_a.mode));
      monitor(1, if_b.mode_changed, if_b.idle_timeout, int'(if_b.mode));
    end
    if (!rst_c) monitor(2, if_c.mode_changed, if_c.idle_timeout, int'(if_c.mode));
  end

  // ---------------- driver tasks ----------------
  task automatic set_btns(input int d, input logic n, input logic p);
    case (d)
      0:       begin if_a.btn_next = n; if_a.btn_prev = p; end
      1:       begin if_b.btn_next = n; if_b.btn_prev = p; end
      default: begin if_c.btn_next = n; if_c.btn_prev = p; end
    endcase
  endtask

  task automatic set_lock(input int d, input logic l);
    case (d)
      0:       if_a.lock = l;
      1:       if_b.lock = l;
      default: if_c.lock = l;
    endcase
  endtask

  // kind: 0 = next, 1 = prev, 2 = both with identical timing.
  // With lockit the lock covers the update edge and drops while still held.
  task automatic press(input int d, input int kind, input int hold, input int gap,
                       input bit lockit, output int upd);
    int k;
    int nm;
    @(negedge clk);
    k   = cyc;
    upd = k + dbc[d] + 4;
    nm  = mode_m[d];
    if (!lockit && kind == 0) nm = (mode_m[d] + 1) % nmodes[d];
    if (!lockit && kind == 1) nm = (mode_m[d] + nmodes[d] - 1) % nmodes[d];
    if (nm != mode_m[d]) qpush(d, upd, nm, 1'b0);
    mode_m[d] = nm;
    if (lockit) set_lock(d, 1'b1);
    set_btns(d, kind != 1, kind != 0);
    if (lockit) begin
      repeat (dbc[d] + 8) @(negedge clk);
      set_lock(d, 1'b0);
      repeat (6) @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
    end
    set_btns(d, 1'b0, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic glitch(input int d, input int kind, input int len, input int gap);
    @(negedge clk);
    set_btns(d, kind != 1, kind != 0);
    repeat (len) @(negedge clk);
    set_btns(d, 1'b0, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 400 && qsize(d) > 0; i++) @(negedge clk);
    if (qsize(d) > 0) begin
      cmp($sformatf("dut%0d expected changes still pending", d), qsize(d), 0);
      qclear(d);
    end
  endtask

  task automatic check_state(input int d, input string tag);
    int m;
    int oh;
    case (d)
      0:       begin m = int'(if_a.mode); oh = int'(if_a.mode_onehot); end
      1:       begin m = int'(if_b.mode); oh = int'(if_b.mode_onehot); end
      default: begin m = int'(if_c.mode); oh = int'(if_c.mode_onehot); end
    endcase
    cmp($sformatf("dut%0d mode %s", d, tag), m, mode_m[d]);
    cmp($sformatf("dut%0d onehot %s", d, tag), oh, 1 << mode_m[d]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int u;
    int op;
    int g;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    rst_c = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mode_m[d] = home[d];
      set_btns(d, 1'b0, 1'b0);
      set_lock(d, 1'b0);
    end
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    rst_c = 1'b0;
    @(negedge clk);

    // Reset state
    for (int d = 0; d < 3; d++) check_state(d, "after reset");
    cmp("dut0 mode_changed after reset", int'(if_a.mode_changed), 0);
    cmp("dut0 idle_timeout after reset", int'(if_a.idle_timeout), 0);
    cmp("dut2 mode_changed after reset", int'(if_c.mode_changed), 0);

    // A: 30-cycle hold, then three clean presses wrapping 3 -> 0
    press(0, 0, 30, 24, 1'b0, u);
    check_state(0, "first press");
    for (int i = 0; i < 3; i++) press(0, 0, 20, 24, 1'b0, u);
    check_state(0, "wrap to 0");

    // A: repeated 10-cycle glitches, then prev from 0 wraps to 3
    for (int i = 0; i < 4; i++) glitch(0, 0, 10, 3);
    repeat (24) @(negedge clk);
    check_state(0, "after glitches");
    press(0, 1, 20, 24, 1'b0, u);
    check_state(0, "prev from 0");

    // A: both buttons together, then a press under lock
    press(0, 2, 22, 24, 1'b0, u);
    check_state(0, "both pressed");
    press(0, 0, 0, 24, 1'b1, u);
    check_state(0, "locked press");

    // A: randomized mix
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 4));
      g  = int'($urandom_range(20, 36));
      case (op)
        0: press(0, 0, int'($urandom_range(16, 28)), g, 1'b0, u);
        1: press(0, 1, int'($urandom_range(16, 28)), g, 1'b0, u);
        2: press(0, 2, int'($urandom_range(16, 28)), g, 1'b0, u);
        3: glitch(0, int'($urandom_range(0, 2)), int'($urandom_range(1, 15)), g);
        default: press(0, int'($urandom_range(0, 1)), 0, g, 1'b1, u);
      endcase
    end
    drain(0);
    check_state(0, "after random");

    // B: reach mode 2, then idle for exactly 100 cycles
    press(1, 0, 20, 22, 1'b0, u);
    press(1, 0, 20, 0, 1'b0, u);
    qpush(1, u + 100, 0, 1'b1);
    mode_m[1] = 0;
    drain(1);
    check_state(1, "after timeout");
    repeat (150) @(negedge clk);
    check_state(1, "idle at home");

    // B: prev to 3, lock for 50 cycles delays return by 50
    press(1, 1, 18, 0, 1'b0, u);
    qpush(1, u + 150, 0, 1'b1);
    mode_m[1] = 0;
    wait_cyc(u + 10);
    set_lock(1, 1'b1);
    wait_cyc(u + 60);
    set_lock(1, 1'b0);
    drain(1);
    check_state(1, "after delayed timeout");

    // C: N=5, home 2: 2->3->4->0, then 0->4
    for (int i = 0; i < 3; i++) press(2, 0, 8, 10, 1'b0, u);
    check_state(2, "wrap 4 to 0");
    press(2, 1, 8, 10, 1'b0, u);
    check_state(2, "wrap 0 to 4");
    drain(2);

    // C: reset in the middle of a debounce; button released during reset
    @(negedge clk);
    set_btns(2, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #3;
    rst_c = 1'b1;
    mode_m[2] = home[2];
    #1;
    check_state(2, "async reset");
    set_btns(2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_c = 1'b0;
    repeat (30) @(negedge clk);
    check_state(2, "after reset release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
